// File: rtl/pixel_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : pixel_result_collector
// Description : Buffers one result per row solver, arbitrates round-robin,
//               maps iteration counts to RGB332 and writes the framebuffer.
//               Optional frame counter: PIXEL_COLLECTOR_FRAME_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_result_collector #(
  parameter int N_SOLVERS = 4,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480
) (
  input  logic                   solver_clk,
  input  logic                   reset_n,
  input  logic [N_SOLVERS*10-1:0] sol_value,
  input  logic [N_SOLVERS*10-1:0] sol_col,
  input  logic [N_SOLVERS*9-1:0]  sol_row,
  input  logic [N_SOLVERS-1:0]    sol_stb,
  input  logic [9:0]              max_iterations,
  output logic [18:0]             fb_addr,
  output logic [7:0]              fb_data,
  output logic                    fb_we,
  input  logic                    fb_ready,
  output logic [N_SOLVERS-1:0]    overflow
`ifdef PIXEL_COLLECTOR_FRAME_COUNT_EN
  ,
  output logic                    frame_done,
  output logic [18:0]             pixel_count
`endif
);

  localparam int PTR_W = (N_SOLVERS > 1) ? $clog2(N_SOLVERS) : 1;

  logic [9:0]           r_slot_value [N_SOLVERS];
  logic [9:0]           r_slot_col   [N_SOLVERS];
  logic [8:0]           r_slot_row   [N_SOLVERS];
  logic [N_SOLVERS-1:0] r_slot_full;
  logic [N_SOLVERS-1:0] r_overflow;
  logic [PTR_W-1:0]     r_ptr;
  logic                 r_fb_we;
  logic [18:0]          r_fb_addr;
  logic [7:0]           r_fb_data;

  logic                 w_can_load;
  logic                 w_found;
  logic                 w_grant;
  logic [PTR_W-1:0]     w_grant_idx;
  logic [N_SOLVERS-1:0] w_grant_vec;
  logic [PTR_W-1:0]     w_ptr_next;
  logic [9:0]           w_sel_value;
  logic [9:0]           w_sel_col;
  logic [8:0]           w_sel_row;
  logic [18:0]          w_row_ext;
  logic [18:0]          w_addr;
  logic [7:0]           w_data;

  // Output register may reload when empty or handing off this cycle.
  assign w_can_load = !r_fb_we || fb_ready;

  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < N_SOLVERS; k++) begin
      for (int j = 0; j < N_SOLVERS; j++) begin
        if (!w_found && r_slot_full[j] && (((int'(r_ptr) + k) % N_SOLVERS) == j)) begin
          w_found     = 1'b1;
          w_grant_idx = PTR_W'(j);
        end
      end
    end
  end

  assign w_grant = w_found && w_can_load;

  always_comb begin
    w_grant_vec = '0;
    for (int j = 0; j < N_SOLVERS; j++) begin
      w_grant_vec[j] = w_grant && (w_grant_idx == PTR_W'(j));
    end
  end

  assign w_ptr_next = (w_grant_idx == PTR_W'(N_SOLVERS - 1)) ? '0 : w_grant_idx + 1'b1;

  assign w_sel_value = r_slot_value[w_grant_idx];
  assign w_sel_col   = r_slot_col[w_grant_idx];
  assign w_sel_row   = r_slot_row[w_grant_idx];
  assign w_row_ext   = {10'd0, w_sel_row};

  generate
    if (H_RES == 640) begin : g_addr_shift
      assign w_addr = (w_row_ext << 9) + (w_row_ext << 7) + {9'd0, w_sel_col};
    end else begin : g_addr_mul
      assign w_addr = w_row_ext * 19'(H_RES) + {9'd0, w_sel_col};
    end
  endgenerate

  // Counts above the escape limit never escaped: the point is in the set.
  assign w_data = (w_sel_value > max_iterations) ? 8'h00
                : {w_sel_value[2:0], w_sel_value[5:3], w_sel_value[7:6]};

  always_ff @(posedge solver_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_full <= '0;
      r_overflow  <= '0;
      for (int i = 0; i < N_SOLVERS; i++) begin
        r_slot_value[i] <= '0;
        r_slot_col[i]   <= '0;
        r_slot_row[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_SOLVERS; i++) begin
        if (sol_stb[i] && (!r_slot_full[i] || w_grant_vec[i])) begin
          r_slot_value[i] <= sol_value[i*10 +: 10];
          r_slot_col[i]   <= sol_col[i*10 +: 10];
          r_slot_row[i]   <= sol_row[i*9 +: 9];
          r_slot_full[i]  <= 1'b1;
        end else if (w_grant_vec[i]) begin
          r_slot_full[i]  <= 1'b0;
        end
        if (sol_stb[i] && r_slot_full[i] && !w_grant_vec[i]) begin
          r_overflow[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge solver_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr     <= '0;
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
    end else begin
      if (w_grant) begin
        r_ptr     <= w_ptr_next;
        r_fb_we   <= 1'b1;
        r_fb_addr <= w_addr;
        r_fb_data <= w_data;
      end else if (fb_ready) begin
        r_fb_we   <= 1'b0;
      end
    end
  end

  assign fb_we    = r_fb_we;
  assign fb_addr  = r_fb_addr;
  assign fb_data  = r_fb_data;
  assign overflow = r_overflow;

`ifdef PIXEL_COLLECTOR_FRAME_COUNT_EN
  localparam logic [18:0] C_FRAME_LAST = 19'(H_RES * V_RES - 1);

  logic        r_frame_done;
  logic [18:0] r_pixel_count;
  logic        w_accept;

  assign w_accept = r_fb_we && fb_ready;

  always_ff @(posedge solver_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_done  <= 1'b0;
      r_pixel_count <= '0;
    end else begin
      r_frame_done <= w_accept && (r_pixel_count == C_FRAME_LAST);
      if (w_accept) begin
        r_pixel_count <= (r_pixel_count == C_FRAME_LAST) ? '0 : r_pixel_count + 19'd1;
      end
    end
  end

  assign frame_done  = r_frame_done;
  assign pixel_count = r_pixel_count;
`endif

endmodule
`default_nettype wire
